// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART receiver with hex display.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StPar,
    StStop,
    StBreak
  } rx_state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/uart_rx_hex_display_hex_to_seg7.sv
// Hex nibble to seven-segment decoder; active-low outputs ordered {g,f,e,d,c,b,a}.
module hex_to_seg7 (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h7F;
    unique case (nibble_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/uart_rx_hex_display.sv
// UART receiver with configurable width/parity; last good word shown on hex digits.
module uart_rx_hex_display
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = PAR_NONE,
  localparam int unsigned NUM_DIGITS  = (DATA_BITS + 3) / 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_serial,
  output logic                    rx_dv,
  output logic [DATA_BITS-1:0]    rx_byte,
  output logic                    parity_err,
  output logic                    frame_err,
  output logic [NUM_DIGITS*7-1:0] ssg
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] CntMax  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

  logic rx_meta_q, rx_s_q;

  rx_state_e state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_bit_q, par_bit_d;
  logic [DATA_BITS-1:0] rx_byte_q, rx_byte_d;
  logic [DATA_BITS-1:0] disp_q, disp_d;
  logic                 disp_valid_q, disp_valid_d;
  logic                 rx_dv_q, rx_dv_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_ok;
  logic                 xor_all;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_serial;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign xor_all = ^{data_q, par_bit_q};

  always_comb begin
    if (PARITY == PAR_EVEN) begin
      parity_ok = ~xor_all;
    end else if (PARITY == PAR_ODD) begin
      parity_ok = xor_all;
    end else begin
      parity_ok = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    data_d       = data_q;
    par_bit_d    = par_bit_q;
    rx_byte_d    = rx_byte_q;
    disp_d       = disp_q;
    disp_valid_d = disp_valid_q;
    rx_dv_d      = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d = '0;
          idx_d = '0;
          // A start bit that is high again at mid-bit was only a glitch.
          state_d = rx_s_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == CntMax) begin
          cnt_d          = '0;
          data_d[idx_q]  = rx_s_q;
          if (idx_q == IdxLast) begin
            state_d = (PARITY != PAR_NONE) ? StPar : StStop;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StPar: begin
        if (cnt_q == CntMax) begin
          cnt_d     = '0;
          par_bit_d = rx_s_q;
          state_d   = StStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == CntMax) begin
          cnt_d     = '0;
          idx_d     = '0;
          rx_byte_d = data_q;
          if (rx_s_q) begin
            state_d = StIdle;
            if (parity_ok) begin
              rx_dv_d      = 1'b1;
              disp_d       = data_q;
              disp_valid_d = 1'b1;
            end else begin
              parity_err_d = 1'b1;
            end
          end else begin
            // Stay in StBreak until the line idles so a held-low line flags once.
            state_d      = StBreak;
            frame_err_d  = 1'b1;
            parity_err_d = ~parity_ok;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StBreak: begin
        if (rx_s_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      idx_q        <= '0;
      data_q       <= '0;
      par_bit_q    <= 1'b0;
      rx_byte_q    <= '0;
      disp_q       <= '0;
      disp_valid_q <= 1'b0;
      rx_dv_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      par_bit_q    <= par_bit_d;
      rx_byte_q    <= rx_byte_d;
      disp_q       <= disp_d;
      disp_valid_q <= disp_valid_d;
      rx_dv_q      <= rx_dv_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign rx_dv      = rx_dv_q;
  assign rx_byte    = rx_byte_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

  logic [NUM_DIGITS*4-1:0] disp_ext;
  assign disp_ext = (NUM_DIGITS * 4)'(disp_q);

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    logic [6:0] seg;
    hex_to_seg7 u_dec (
      .nibble_i (disp_ext[4*k +: 4]),
      .seg_o    (seg)
    );
    assign ssg[7*k +: 7] = disp_valid_q ? seg : SEG_BLANK;
  end

endmodule

// File: tb/tb_uart_rx_hex_display.sv
// Directed bench: three receiver instances (8N1, 8E1, 9N1) driven with hand-built frames.
module tb_uart_rx_hex_display;

  localparam int unsigned CPB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx0 = 1'b1;
  logic rx1 = 1'b1;
  logic rx2 = 1'b1;

  logic        dv_0, pe_0, fe_0;
  logic [7:0]  byte_0;
  logic [13:0] ssg_0;
  logic        dv_1, pe_1, fe_1;
  logic [7:0]  byte_1;
  logic [13:0] ssg_1;
  logic        dv_2, pe_2, fe_2;
  logic [8:0]  byte_2;
  logic [20:0] ssg_2;

  int n_checks = 0;
  int n_fails  = 0;
  int dv_cnt0 = 0, pe_cnt0 = 0, fe_cnt0 = 0;
  int dv_cnt1 = 0, pe_cnt1 = 0, fe_cnt1 = 0;
  int dv_cnt2 = 0, pe_cnt2 = 0, fe_cnt2 = 0;
  int both_cnt = 0;
  int d0, p0, f0, d1, p1, d2;

  always #5 clk = ~clk;

  uart_rx_hex_display #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0)) u_dut0 (
    .clk(clk), .rst(rst), .rx_serial(rx0), .rx_dv(dv_0), .rx_byte(byte_0),
    .parity_err(pe_0), .frame_err(fe_0), .ssg(ssg_0)
  );

  uart_rx_hex_display #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1)) u_dut1 (
    .clk(clk), .rst(rst), .rx_serial(rx1), .rx_dv(dv_1), .rx_byte(byte_1),
    .parity_err(pe_1), .frame_err(fe_1), .ssg(ssg_1)
  );

  uart_rx_hex_display #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY(0)) u_dut2 (
    .clk(clk), .rst(rst), .rx_serial(rx2), .rx_dv(dv_2), .rx_byte(byte_2),
    .parity_err(pe_2), .frame_err(fe_2), .ssg(ssg_2)
  );

  // Count strobe-high cycles so a stretched pulse shows up as an extra count.
  always @(posedge clk) begin
    if (dv_0) dv_cnt0 <= dv_cnt0 + 1;
    if (pe_0) pe_cnt0 <= pe_cnt0 + 1;
    if (fe_0) fe_cnt0 <= fe_cnt0 + 1;
    if (dv_1) dv_cnt1 <= dv_cnt1 + 1;
    if (pe_1) pe_cnt1 <= pe_cnt1 + 1;
    if (fe_1) fe_cnt1 <= fe_cnt1 + 1;
    if (dv_2) dv_cnt2 <= dv_cnt2 + 1;
    if (pe_2) pe_cnt2 <= pe_cnt2 + 1;
    if (fe_2) fe_cnt2 <= fe_cnt2 + 1;
    if ((dv_0 && fe_0) || (dv_1 && fe_1) || (dv_2 && fe_2)) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v);
    case (sel)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  task automatic send_bit(input int sel, input logic v);
    drive(sel, v);
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int sel, input int n);
    drive(sel, 1'b1);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the line at the stop-bit level so back-to-back and break cases compose.
  task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                            input bit use_par, input logic par, input logic stop);
    send_bit(sel, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(sel, data[i]);
    if (use_par) send_bit(sel, par);
    send_bit(sel, stop);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    check("reset_rx_dv", 32'(dv_0), 32'h0);
    check("reset_rx_byte", 32'(byte_0), 32'h0);
    check("reset_parity_err", 32'(pe_0), 32'h0);
    check("reset_frame_err", 32'(fe_0), 32'h0);
    check("reset_ssg0", 32'(ssg_0), 32'h3FFF);
    check("reset_ssg2", 32'(ssg_2), 32'h1FFFFF);

    // Good 8N1 frame 0xA5
    send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1);
    idle(0, 20);
    check("a5_dv_count", 32'(dv_cnt0), 32'd1);
    check("a5_rx_byte", 32'(byte_0), 32'hA5);
    check("a5_digit0", 32'(ssg_0[6:0]), 32'h12);
    check("a5_digit1", 32'(ssg_0[13:7]), 32'h08);
    check("a5_no_errs", 32'(pe_cnt0 + fe_cnt0), 32'd0);

    // Glitch: 2 clocks low
    d0 = dv_cnt0; p0 = pe_cnt0; f0 = fe_cnt0;
    drive(0, 1'b0);
    repeat (2) @(negedge clk);
    idle(0, 40);
    check("glitch_dv", 32'(dv_cnt0), 32'(d0));
    check("glitch_pe", 32'(pe_cnt0), 32'(p0));
    check("glitch_fe", 32'(fe_cnt0), 32'(f0));

    // Framing error: 0x5A with stop 0, line held low a further 30 clocks
    send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1'b0);
    repeat (30) @(negedge clk);
    idle(0, 20);
    check("ferr_fe_count", 32'(fe_cnt0), 32'(f0 + 1));
    check("ferr_no_dv", 32'(dv_cnt0), 32'(d0));
    check("ferr_no_pe", 32'(pe_cnt0), 32'(p0));
    check("ferr_rx_byte", 32'(byte_0), 32'h5A);
    check("ferr_display_kept", 32'(ssg_0), {18'h0, 7'h08, 7'h12});

    // Recovery frame 0x3C
    send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1'b1);
    idle(0, 20);
    check("recover_dv_count", 32'(dv_cnt0), 32'(d0 + 1));
    check("recover_rx_byte", 32'(byte_0), 32'h3C);
    check("recover_digit0", 32'(ssg_0[6:0]), 32'h46);
    check("recover_digit1", 32'(ssg_0[13:7]), 32'h30);

    // Even parity: good 0x81 (parity bit 0), then 0x03 with a wrong parity bit 1
    send_frame(1, 9'h081, 8, 1'b1, 1'b0, 1'b1);
    idle(1, 20);
    check("par_good_dv", 32'(dv_cnt1), 32'd1);
    check("par_good_byte", 32'(byte_1), 32'h81);
    check("par_good_ssg", 32'(ssg_1), {18'h0, 7'h00, 7'h79});
    d1 = dv_cnt1; p1 = pe_cnt1;
    send_frame(1, 9'h003, 8, 1'b1, 1'b1, 1'b1);
    idle(1, 20);
    check("par_bad_pe_count", 32'(pe_cnt1), 32'(p1 + 1));
    check("par_bad_no_dv", 32'(dv_cnt1), 32'(d1));
    check("par_bad_no_fe", 32'(fe_cnt1), 32'd0);
    check("par_bad_rx_byte", 32'(byte_1), 32'h03);
    check("par_bad_display_kept", 32'(ssg_1), {18'h0, 7'h00, 7'h79});

    // 9-bit back-to-back frames 0x1FF then 0x001 with no idle gap
    d2 = dv_cnt2;
    send_frame(2, 9'h1FF, 9, 1'b0, 1'b0, 1'b1);
    check("b2b_first_dv", 32'(dv_cnt2), 32'(d2 + 1));
    check("b2b_first_byte", 32'(byte_2), 32'h1FF);
    check("b2b_first_ssg", 32'(ssg_2), {11'h0, 7'h79, 7'h0E, 7'h0E});
    send_frame(2, 9'h001, 9, 1'b0, 1'b0, 1'b1);
    idle(2, 20);
    check("b2b_second_dv", 32'(dv_cnt2), 32'(d2 + 2));
    check("b2b_second_byte", 32'(byte_2), 32'h001);
    check("b2b_second_ssg", 32'(ssg_2), {11'h0, 7'h40, 7'h40, 7'h79});
    check("b2b_no_errs", 32'(pe_cnt2 + fe_cnt2), 32'd0);

    // Reset during data bit 4
    d0 = dv_cnt0; p0 = pe_cnt0; f0 = fe_cnt0;
    send_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(0, 1'b0);
    drive(0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    drive(0, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(0, 100);
    check("rst_mid_dv", 32'(dv_cnt0), 32'(d0));
    check("rst_mid_pe", 32'(pe_cnt0), 32'(p0));
    check("rst_mid_fe", 32'(fe_cnt0), 32'(f0));
    check("rst_mid_blank", 32'(ssg_0), 32'h3FFF);
    check("rst_mid_rx_byte", 32'(byte_0), 32'h0);

    send_frame(0, 9'h011, 8, 1'b0, 1'b0, 1'b1);
    idle(0, 20);
    check("after_rst_dv", 32'(dv_cnt0), 32'(d0 + 1));
    check("after_rst_byte", 32'(byte_0), 32'h11);
    check("after_rst_ssg", 32'(ssg_0), {18'h0, 7'h79, 7'h79});

    check("dv_fe_never_together", 32'(both_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_hex_display.md
Name: uart_rx_hex_display

Overview:
- Parametrised successor to the fixed 8-bit UART receive top level.
- Receives asynchronous serial frames with configurable data width and optional parity, and flags framing and parity errors.
- Holds the last good word and drives one hex seven-segment digit per nibble.
- Sits between the board RX pin and the board display; also exports the received word and strobes to downstream logic.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); legal range >= 4.
- DATA_BITS, 8, data bits per frame; legal range 5..9; sent LSB first.
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
- NUM_DIGITS (localparam), ceil(DATA_BITS/4), number of display digits.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_serial  in  1  asynchronous serial line; idle high.
- rx_dv  out  1  one-cycle strobe: a good frame was received.
- rx_byte  out  DATA_BITS  data of the most recently completed frame.
- parity_err  out  1  one-cycle strobe: parity mismatch.
- frame_err  out  1  one-cycle strobe: stop bit sampled low.
- ssg  out  NUM_DIGITS*7  segments, active-low.
  - Digit k is ssg[7k+6:7k] and shows nibble k of the display register.
  - Bit order within a digit is {g,f,e,d,c,b,a}.

Behaviour:
- Input synchronisation: rx_serial passes through a 2-flop synchroniser giving rx_s. The FSM sees only rx_s, so there are 2 cycles of input latency. Synchroniser flops reset to 1.
- Reset values:
  - rx_dv, parity_err and frame_err are 0.
  - rx_byte is 0.
  - The display register is blank, so every digit is 7'h7F.
  - The FSM is in IDLE with the bit counter at 0.
- FSM states: IDLE, START, DATA, PAR, STOP, BREAK.
  - IDLE: when rx_s == 0, go to START and clear the clock counter.
  - START: at count (CLKS_PER_BIT-1)/2, re-sample rx_s.
    - If 0, go to DATA and clear the counter.
    - If 1, treat it as a glitch and return to IDLE with no strobe.
  - DATA: each time the count reaches CLKS_PER_BIT-1, shift rx_s into bit[idx] and clear the counter. After DATA_BITS samples, go to PAR if PARITY != 0, otherwise go to STOP.
  - PAR: sample at CLKS_PER_BIT-1, then go to STOP.
    - Even parity: XOR of the data bits and the parity bit must be 0.
    - Odd parity: the same XOR must be 1.
  - STOP: sample at CLKS_PER_BIT-1 (mid stop bit).
    - rx_byte loads the received data on every completed frame.
    - Stop bit 1 and parity OK: pulse rx_dv on the next cycle, load the display register, go to IDLE.
    - Stop bit 1 and parity bad: pulse parity_err, display unchanged, go to IDLE.
    - Stop bit 0: pulse frame_err, go to BREAK. parity_err may pulse in the same cycle if parity was also bad. rx_dv stays 0.
  - BREAK: remain until rx_s == 1, then go to IDLE. A held-low line therefore produces exactly one frame_err.
- Strobes: all strobes are registered and last exactly 1 cycle. rx_dv and frame_err are never asserted together.
- Back-to-back frames: the FSM returns to IDLE half a bit before the stop bit ends, so a start bit immediately following the stop bit is accepted.
- Reset mid-frame: the FSM returns to IDLE immediately, any partial word is discarded, and no strobe is issued.
- Display:
  - Hex decode covers 0-F.
  - For DATA_BITS not a multiple of 4, the top digit zero-extends its nibble.
  - Decode is combinational from the display register.

Decomposition:
- Package uart_pkg holds:
  - the FSM state enum;
  - parity mode constants PAR_NONE, PAR_EVEN, PAR_ODD;
  - the SEG_BLANK constant (7'h7F).
- Sub-module hex_to_seg7: a 4-bit to 7-bit active-low decoder, instantiated NUM_DIGITS times with a generate loop.
- The synchroniser and FSM stay in the top module.

Test Plan:
- Good frame: CLKS_PER_BIT=8, PARITY=0; send 0xA5 with stop bit 1.
  - Expect one rx_dv pulse and rx_byte=0xA5.
  - Expect ssg[6:0]=7'h12 ("5") and ssg[13:7]=7'h08 ("A").
- Parity error: PARITY=1; send 0x03 with parity bit 1.
  - Expect parity_err pulse, no rx_dv.
  - Expect rx_byte=0x03 and display unchanged from its prior value.
- Glitch rejection: drive rx_serial low for 2 clk, then high. Expect no strobes and the FSM back in IDLE.
- Framing error then recovery: send 0x5A with stop bit 0 and hold low 30 clk.
  - Expect a single frame_err pulse.
  - Then release the line and send 0x3C. Expect rx_dv with rx_byte=0x3C.
- Reset mid-frame: assert rst during data bit 4.
  - Expect no strobes and all digits 7'h7F.
  - A following 0x11 frame is received correctly.
- Back-to-back frames: DATA_BITS=9, send 0x1FF then 0x001 with no idle gap. Expect two rx_dv pulses and ssg digits showing 1,F,F then 0,0,1.
